// File: rtl/alu_gumnut.sv
// Gumnut-style 8-bit ALU. It decodes the instruction class and produces a combinational result.
// The registered carry/zero flags update only in execute cycles of the ALU and shift classes.
module alu_gumnut (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_en,
  input  logic [7:0]  GPR_rs,
  input  logic [7:0]  GPR_r2,
  input  logic [17:0] IR,
  output logic [7:0]  ALU_result,
  output logic        ALU_C,
  output logic        ALU_Z
);

  typedef enum logic [2:0] {
    CLS_ALU_IMM = 3'd0,
    CLS_MEM     = 3'd1,
    CLS_SHIFT   = 3'd2,
    CLS_ALU_REG = 3'd3,
    CLS_NONE    = 3'd4
  } cls_e;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_ADDC = 3'b001,
    FN_SUB  = 3'b010,
    FN_SUBC = 3'b011,
    FN_AND  = 3'b100,
    FN_OR   = 3'b101,
    FN_XOR  = 3'b110,
    FN_MASK = 3'b111
  } alu_fn_e;

  typedef enum logic [1:0] {
    SH_SHL = 2'b00,
    SH_SHR = 2'b01,
    SH_ROL = 2'b10,
    SH_ROR = 2'b11
  } sh_fn_e;

  logic       c_q, c_d;
  logic       z_q, z_d;

  cls_e       cls;
  alu_fn_e    alu_fn;
  sh_fn_e     sh_fn;
  logic [2:0] sh_cnt;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] c_ext;

  logic [8:0] alu_sum;
  logic [7:0] alu_res;
  logic       alu_c_next;

  logic [15:0] shl_w;
  logic [15:0] shr_w;
  logic [15:0] rol_w;
  logic [15:0] ror_w;
  logic [7:0]  sh_res;
  logic        sh_c_next;

  logic [7:0] result;
  logic       c_next;
  logic       upd_class;

  // Register-number fields are consumed by the register file, not here.
  logic unused_ir;
  assign unused_ir = ^{IR[13:8], IR[4:2]};

  // Class decode, first match wins.
  always_comb begin
    cls = CLS_NONE;
    if (!IR[17])                 cls = CLS_ALU_IMM;
    else if (!IR[16])            cls = CLS_MEM;
    else if (!IR[15])            cls = CLS_SHIFT;
    else if (!IR[14])            cls = CLS_ALU_REG;
  end

  assign a      = GPR_rs;
  assign sh_cnt = IR[7:5];
  assign sh_fn  = sh_fn_e'(IR[1:0]);
  assign c_ext  = {8'h00, c_q};

  always_comb begin
    alu_fn = alu_fn_e'(IR[2:0]);
    b      = GPR_r2;
    if (cls == CLS_ALU_IMM) begin
      alu_fn = alu_fn_e'(IR[16:14]);
      b      = IR[7:0];
    end
  end

  // 9-bit arithmetic: bit 8 is the carry for adds and the borrow for subtracts.
  always_comb begin
    alu_sum = 9'h000;
    alu_res = 8'h00;
    unique case (alu_fn)
      FN_ADD:  alu_sum = {1'b0, a} + {1'b0, b};
      FN_ADDC: alu_sum = {1'b0, a} + {1'b0, b} + c_ext;
      FN_SUB:  alu_sum = {1'b0, a} - {1'b0, b};
      FN_SUBC: alu_sum = {1'b0, a} - {1'b0, b} - c_ext;
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_XOR:  alu_res = a ^ b;
      FN_MASK: alu_res = a & ~b;
      default: alu_res = 8'h00;
    endcase
    if (!alu_fn[2]) alu_res = alu_sum[7:0];
    alu_c_next = alu_fn[2] ? 1'b0 : alu_sum[8];
  end

  // Shifts run in a 16-bit window so the last bit out lands at a fixed position.
  always_comb begin
    shl_w = {8'h00, a} << sh_cnt;
    shr_w = {a, 8'h00} >> sh_cnt;
    rol_w = {a, a} << sh_cnt;
    ror_w = {a, a} >> sh_cnt;
    sh_res    = a;
    sh_c_next = 1'b0;
    unique case (sh_fn)
      SH_SHL: begin sh_res = shl_w[7:0];  sh_c_next = shl_w[8]; end
      SH_SHR: begin sh_res = shr_w[15:8]; sh_c_next = shr_w[7]; end
      SH_ROL: sh_res = rol_w[15:8];
      SH_ROR: sh_res = ror_w[7:0];
      default: sh_res = a;
    endcase
  end

  always_comb begin
    result    = 8'h00;
    c_next    = 1'b0;
    upd_class = 1'b0;
    unique case (cls)
      CLS_ALU_IMM, CLS_ALU_REG: begin
        result    = alu_res;
        c_next    = alu_c_next;
        upd_class = 1'b1;
      end
      CLS_SHIFT: begin
        result    = sh_res;
        c_next    = sh_c_next;
        upd_class = 1'b1;
      end
      CLS_MEM: result = a + IR[7:0];
      default: result = 8'h00;
    endcase
  end

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    if (flag_en && upd_class) begin
      c_d = c_next;
      z_d = (result == 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign ALU_result = result;
  assign ALU_C      = c_q;
  assign ALU_Z      = z_q;

endmodule

// File: tb/tb_alu_gumnut.sv
// Directed bench for alu_gumnut: combinational results and registered C/Z flags,
// with hand-computed expectations.
module tb_alu_gumnut;

  logic        clk;
  logic        rst_n;
  logic        flag_en;
  logic [7:0]  GPR_rs;
  logic [7:0]  GPR_r2;
  logic [17:0] IR;
  logic [7:0]  ALU_result;
  logic        ALU_C;
  logic        ALU_Z;

  int checks = 0;
  int errors = 0;

  alu_gumnut dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_en    (flag_en),
    .GPR_rs     (GPR_rs),
    .GPR_r2     (GPR_r2),
    .IR         (IR),
    .ALU_result (ALU_result),
    .ALU_C      (ALU_C),
    .ALU_Z      (ALU_Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] R_ADD  = 18'b111000000000000000;
  localparam logic [17:0] R_ADDC = 18'b111000000000000001;
  localparam logic [17:0] R_SUB  = 18'b111000000000000010;
  localparam logic [17:0] R_SUBC = 18'b111000000000000011;

  function automatic logic [17:0] imm_ir(input logic [2:0] fn, input logic [7:0] imm);
    return {1'b0, fn, 6'b000000, imm};
  endfunction

  function automatic logic [17:0] sh_ir(input logic [1:0] fn, input logic [2:0] cnt);
    return {3'b110, 7'b0000000, cnt, 3'b000, fn};
  endfunction

  function automatic logic [17:0] mem_ir(input logic [7:0] imm);
    return {2'b10, 8'h00, imm};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_c, input logic exp_z);
    checks++;
    assert ({ALU_C, ALU_Z} === {exp_c, exp_z}) else begin
      errors++;
      $error("FAIL %s observed C=%b Z=%b expected C=%b Z=%b", tag, ALU_C, ALU_Z, exp_c, exp_z);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [17:0] ir, input logic [7:0] rs, input logic [7:0] r2);
    IR     = ir;
    GPR_rs = rs;
    GPR_r2 = r2;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flag_en = 1'b0; IR = '0; GPR_rs = '0; GPR_r2 = '0;
    step();
    check_flags("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    flag_en = 1'b1;

    apply(R_ADD, 8'd5, 8'd5);      check8("reg_add", ALU_result, 8'd10);
    step();                        check_flags("reg_add_flags", 1'b0, 1'b0);

    apply(R_SUB, 8'd5, 8'd5);      check8("reg_sub_zero", ALU_result, 8'd0);
    step();                        check_flags("reg_sub_zero_flags", 1'b0, 1'b1);
    apply(R_SUB, 8'd3, 8'd5);      check8("reg_sub_borrow", ALU_result, 8'd254);
    step();                        check_flags("reg_sub_borrow_flags", 1'b1, 1'b0);

    apply(R_ADD, 8'd200, 8'd100);  check8("add_carry", ALU_result, 8'd44);
    step();                        check_flags("add_carry_flags", 1'b1, 1'b0);
    apply(R_ADDC, 8'd3, 8'd2);     check8("addc_c1", ALU_result, 8'd6);
    step();                        check_flags("addc_flags", 1'b0, 1'b0);
    apply(R_SUBC, 8'd4, 8'd1);     check8("subc_c0", ALU_result, 8'd3);
    step();                        check_flags("subc_flags", 1'b0, 1'b0);
    apply(R_ADD, 8'd255, 8'd1);    check8("add_wrap_zero", ALU_result, 8'd0);
    step();                        check_flags("add_wrap_flags", 1'b1, 1'b1);
    apply(R_SUBC, 8'd0, 8'd0);     check8("subc_c1_wrap", ALU_result, 8'd255);
    step();                        check_flags("subc_wrap_flags", 1'b1, 1'b0);

    apply(R_SUB, 8'd5, 8'd5);      step();
    apply(imm_ir(3'b000, 8'd10), 8'd125, 8'd0);  check8("imm_add", ALU_result, 8'd135);
    step();                        check_flags("imm_add_flags", 1'b0, 1'b0);
    apply(imm_ir(3'b001, 8'd10), 8'd125, 8'd0);  check8("imm_addc_c0", ALU_result, 8'd135);
    apply(R_SUB, 8'd3, 8'd5);      step();
    apply(imm_ir(3'b001, 8'd10), 8'd125, 8'd0);  check8("imm_addc_c1", ALU_result, 8'd136);
    step();                        check_flags("imm_addc_flags", 1'b0, 1'b0);

    apply(R_SUB, 8'd3, 8'd5);      step();
    apply(imm_ir(3'b100, 8'h0F), 8'hA5, 8'd0);   check8("imm_and", ALU_result, 8'h05);
    step();                        check_flags("imm_and_clears_c", 1'b0, 1'b0);
    apply(imm_ir(3'b101, 8'h0F), 8'hA0, 8'd0);   check8("imm_or", ALU_result, 8'hAF);
    apply(imm_ir(3'b110, 8'hFF), 8'hA5, 8'd0);   check8("imm_xor", ALU_result, 8'h5A);
    apply(imm_ir(3'b111, 8'h0F), 8'hA5, 8'd0);   check8("imm_mask", ALU_result, 8'hA0);

    apply(sh_ir(2'b00, 3'd1), 8'h81, 8'd0);      check8("shl1", ALU_result, 8'h02);
    step();                        check_flags("shl1_flags", 1'b1, 1'b0);
    apply(sh_ir(2'b01, 3'd1), 8'h81, 8'd0);      check8("shr1", ALU_result, 8'h40);
    step();                        check_flags("shr1_flags", 1'b1, 1'b0);
    apply(sh_ir(2'b10, 3'd1), 8'h81, 8'd0);      check8("rol1", ALU_result, 8'h03);
    step();                        check_flags("rol1_flags", 1'b0, 1'b0);
    apply(sh_ir(2'b11, 3'd4), 8'h81, 8'd0);      check8("ror4", ALU_result, 8'h18);
    apply(sh_ir(2'b00, 3'd3), 8'h81, 8'd0);      check8("shl3", ALU_result, 8'h08);
    step();                        check_flags("shl3_flags", 1'b0, 1'b0);
    apply(sh_ir(2'b01, 3'd1), 8'h01, 8'd0);      check8("shr_to_zero", ALU_result, 8'h00);
    step();                        check_flags("shr_to_zero_flags", 1'b1, 1'b1);
    apply(sh_ir(2'b00, 3'd0), 8'h81, 8'd0);      check8("shift_cnt0", ALU_result, 8'h81);
    step();                        check_flags("shift_cnt0_flags", 1'b0, 1'b0);

    flag_en = 1'b0;
    apply(R_SUB, 8'd5, 8'd5);      check8("hold_result", ALU_result, 8'd0);
    step();                        check_flags("hold_flags", 1'b0, 1'b0);
    flag_en = 1'b1;

    apply(R_SUB, 8'd3, 8'd5);      step();
    apply(mem_ir(8'd10), 8'd250, 8'd0);          check8("mem_addr", ALU_result, 8'd4);
    step();                        check_flags("mem_flags_hold", 1'b1, 1'b0);
    apply(18'b111100000000000000, 8'd7, 8'd9);   check8("other_class", ALU_result, 8'd0);
    step();                        check_flags("other_flags_hold", 1'b1, 1'b0);

    rst_n = 1'b0;
    apply(R_SUB, 8'd3, 8'd5);      check8("result_in_reset", ALU_result, 8'd254);
    step();                        check_flags("reset_over_flag_en", 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
